// File: rtl/axi_rd_arbiter_pkg.sv
// Shared constants and types for the AXI read-channel arbiter.
//   - transaction IDs of the two cache clients
//   - cache rd_type codes
//   - FSM state encoding
//   - AXI burst type
package axi_rd_arbiter_pkg;

  localparam logic [3:0] ID_ICACHE = 4'd0;
  localparam logic [3:0] ID_DCACHE = 4'd1;

  localparam logic [2:0] TYPE_BYTE = 3'b000;
  localparam logic [2:0] TYPE_HALF = 3'b001;
  localparam logic [2:0] TYPE_WORD = 3'b010;
  localparam logic [2:0] TYPE_LINE = 3'b100;

  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_AR   = S_AR,
    ST_R    = S_R
  } state_t;

  // Byte/half/word singles encode arsize directly in the low type bits.
  function automatic logic [2:0] single_size(logic [2:0] t);
    return {1'b0, t[1:0]};
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read address / read data channel bundle.
//   master : drives AR payload, arvalid, rready; receives arready and R beats
//   slave  : the interconnect side
interface axi_rd_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]        arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd_arbiter_grant2.sv
// Two-requester grant for the read arbiter.
//   req_i[0] icache, req_i[1] dcache; gnt_o one-hot (or zero).
//   accept_i : the granted request was taken this cycle.
// Build option ARB_RR_EN: round-robin on simultaneous requests (the side
// that did not win last time wins). Default: dcache has fixed priority.
module arb_grant2 (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] gnt_o
);
  // 1 = dcache took the most recent accepted grant. Reset to icache so the
  // first contest goes to dcache in both builds.
  logic last_q;

  always_ff @(posedge aclk) begin
    if (!aresetn)      last_q <= 1'b0;
    else if (accept_i) last_q <= gnt_o[1];
  end

`ifdef ARB_RR_EN
  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) gnt_o = last_q ? 2'b01 : 2'b10;
  end
`else
  logic unused_last;
  assign unused_last = last_q;
  assign gnt_o = req_i[1] ? 2'b10 : {1'b0, req_i[0]};
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between icache and dcache read ports.
// One request at a time: accept (IDLE) -> issue AR -> collect R beats,
// routing each beat to the owner by ID and checking burst framing.
//   ic_* / dc_* : sram-like request (req/type/addr -> rdy) and return
//                 (ret_valid/ret_last/ret_data) per cache
//   axi         : AXI AR/R master
//   busy        : a transaction is in flight
//   protocol_err: sticky framing / ID error
// Build option ARB_RR_EN selects round-robin grant (see arb_grant2).
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              ic_rd_req,
  input  logic [2:0]        ic_rd_type,
  input  logic [ADDR_W-1:0] ic_rd_addr,
  output logic              ic_rd_rdy,
  output logic              ic_ret_valid,
  output logic              ic_ret_last,
  output logic [DATA_W-1:0] ic_ret_data,
  input  logic              dc_rd_req,
  input  logic [2:0]        dc_rd_type,
  input  logic [ADDR_W-1:0] dc_rd_addr,
  output logic              dc_rd_rdy,
  output logic              dc_ret_valid,
  output logic              dc_ret_last,
  output logic [DATA_W-1:0] dc_ret_data,
  axi_rd_arbiter_if.master  axi,
  output logic              busy,
  output logic              protocol_err
);
  localparam logic [3:0] LINE_LEN  = 4'(BURST_LEN - 1);
  localparam logic [2:0] LINE_SIZE = 3'($clog2(DATA_W / 8));

  state_t            state_q, state_d;
  logic [3:0]        id_q, id_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [1:0]        gnt;
  logic              accept;
  logic [2:0]        sel_type;
  logic              final_beat;

  arb_grant2 u_grant (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .req_i    ({dc_rd_req, ic_rd_req}),
    .accept_i (accept),
    .gnt_o    (gnt)
  );

  assign sel_type   = gnt[1] ? dc_rd_type : ic_rd_type;
  assign final_beat = (cnt_q == len_q);

  assign axi.arid    = id_q;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = len_q;
  assign axi.arsize  = size_q;
  assign axi.arburst = BURST_INCR;

  // Data is a straight pass-through; ret_valid qualifies it.
  assign ic_ret_data  = axi.rdata;
  assign dc_ret_data  = axi.rdata;
  assign busy         = (state_q != ST_IDLE);
  assign protocol_err = err_q;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    accept       = 1'b0;
    ic_rd_rdy    = 1'b0;
    dc_rd_rdy    = 1'b0;
    ic_ret_valid = 1'b0;
    ic_ret_last  = 1'b0;
    dc_ret_valid = 1'b0;
    dc_ret_last  = 1'b0;
    axi.arvalid  = 1'b0;
    axi.rready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Handshake outputs are held low while reset is asserted.
        ic_rd_rdy = aresetn & gnt[0];
        dc_rd_rdy = aresetn & gnt[1];
        if (aresetn && gnt != 2'b00) begin
          accept  = 1'b1;
          id_d    = gnt[1] ? ID_DCACHE : ID_ICACHE;
          addr_d  = gnt[1] ? dc_rd_addr : ic_rd_addr;
          len_d   = (sel_type == TYPE_LINE) ? LINE_LEN : 4'd0;
          size_d  = (sel_type == TYPE_LINE) ? LINE_SIZE : single_size(sel_type);
          state_d = ST_AR;
        end
      end
      ST_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) begin
          cnt_d   = 4'd0;
          state_d = ST_R;
        end
      end
      ST_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          if (axi.rid != id_q) begin
            err_d = 1'b1;  // foreign beat: drop it
          end else begin
            cnt_d        = cnt_q + 4'd1;
            ic_ret_valid = aresetn & (id_q == ID_ICACHE);
            dc_ret_valid = aresetn & (id_q == ID_DCACHE);
            // A missing rlast on the final beat still closes the transfer
            // for the cache.
            ic_ret_last  = ic_ret_valid & (axi.rlast | final_beat);
            dc_ret_last  = dc_ret_valid & (axi.rlast | final_beat);
            if (final_beat) begin
              if (!axi.rlast) err_d = 1'b1;
              state_d = ST_IDLE;
            end else if (axi.rlast) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      id_q    <= 4'd0;
      addr_q  <= '0;
      len_q   <= 4'd0;
      size_q  <= 3'd0;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed transactions, a transaction-level
// reference model checked every cycle, plus literal expectations per case.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 16;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          ic_rd_req = 1'b0, dc_rd_req = 1'b0;
  logic [2:0]    ic_rd_type = '0, dc_rd_type = '0;
  logic [AW-1:0] ic_rd_addr = '0, dc_rd_addr = '0;
  logic          ic_rd_rdy, ic_ret_valid, ic_ret_last;
  logic          dc_rd_rdy, dc_ret_valid, dc_ret_last;
  logic [DW-1:0] ic_ret_data, dc_ret_data;
  logic          busy, protocol_err;

  axi_rd_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) axi ();

  always #5 aclk = ~aclk;

  axi_rd_arbiter #(.BURST_LEN(BL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr),
    .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid),
    .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr),
    .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid),
    .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .axi(axi), .busy(busy), .protocol_err(protocol_err)
  );

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit            m_have, m_ar_done, m_err, m_last_dc, m_dc;
  int            m_left;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_len;
  logic [2:0]    m_size;

  function automatic bit dc_wins(bit icr, bit dcr);
    if (!dcr) return 1'b0;
    if (!icr) return 1'b1;
    if (RR) return !m_last_dc;
    return 1'b1;
  endfunction

  always @(posedge aclk) begin
    logic [2:0] t;
    if (!aresetn) begin
      m_have = 0; m_ar_done = 0; m_err = 0; m_last_dc = 0; m_left = 0;
    end else if (!m_have) begin
      if (ic_rd_req || dc_rd_req) begin
        m_dc      = dc_wins(ic_rd_req, dc_rd_req);
        m_last_dc = m_dc;
        m_have    = 1; m_ar_done = 0;
        t         = m_dc ? dc_rd_type : ic_rd_type;
        m_addr    = m_dc ? dc_rd_addr : ic_rd_addr;
        m_len     = (t == 3'b100) ? 4'(BL - 1) : 4'd0;
        m_size    = (t == 3'b100) ? 3'($clog2(DW / 8)) : {1'b0, t[1:0]};
      end
    end else if (!m_ar_done) begin
      if (axi.arready) begin
        m_ar_done = 1;
        m_left    = int'(m_len) + 1;
      end
    end else if (axi.rvalid) begin
      if (axi.rid != (m_dc ? 4'd1 : 4'd0)) m_err = 1;
      else if (m_left == 1) begin
        if (!axi.rlast) m_err = 1;
        m_have = 0;
      end else if (axi.rlast) begin
        m_err = 1; m_have = 0;
      end else m_left--;
    end
  end

  always @(negedge aclk) begin
    bit beat, ic_w, dc_w, fin;
    if (chk_on) begin
      dc_w = aresetn && !m_have && dc_rd_req && dc_wins(ic_rd_req, dc_rd_req);
      ic_w = aresetn && !m_have && ic_rd_req && !dc_wins(ic_rd_req, dc_rd_req);
      beat = aresetn && m_have && m_ar_done && axi.rvalid &&
             (axi.rid == (m_dc ? 4'd1 : 4'd0));
      fin  = axi.rlast || (m_left == 1);
      chk("busy", 64'(busy), 64'(m_have));
      chk("protocol_err", 64'(protocol_err), 64'(m_err));
      chk("ic_rd_rdy", 64'(ic_rd_rdy), 64'(ic_w));
      chk("dc_rd_rdy", 64'(dc_rd_rdy), 64'(dc_w));
      chk("arvalid", 64'(axi.arvalid), 64'(m_have && !m_ar_done));
      chk("rready", 64'(axi.rready), 64'(m_have && m_ar_done));
      chk("ic_ret_valid", 64'(ic_ret_valid), 64'(beat && !m_dc));
      chk("dc_ret_valid", 64'(dc_ret_valid), 64'(beat && m_dc));
      chk("ic_ret_last", 64'(ic_ret_last), 64'(beat && !m_dc && fin));
      chk("dc_ret_last", 64'(dc_ret_last), 64'(beat && m_dc && fin));
      if (m_have && !m_ar_done) begin
        chk("araddr", 64'(axi.araddr), 64'(m_addr));
        chk("arid", 64'(axi.arid), 64'(m_dc ? 4'd1 : 4'd0));
        chk("arlen", 64'(axi.arlen), 64'(m_len));
        chk("arsize", 64'(axi.arsize), 64'(m_size));
        chk("arburst", 64'(axi.arburst), 64'(2'b01));
      end
      if (beat) chk("ret_data", 64'(m_dc ? dc_ret_data : ic_ret_data), 64'(axi.rdata));
    end
  end

  // ---------------- stimulus helpers (start/end at posedge+1) ----------------
  int bv_ic, bl_ic, bv_dc, bl_dc;

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  task automatic do_ar();
    axi.arready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge aclk);
      if (axi.arvalid) break;
      tick();
    end
    chk("ar_handshake_seen", 64'(axi.arvalid), 64'(1));
    tick();
    axi.arready = 1'b0;
  endtask

  task automatic beats(logic [3:0] id, int n, int last_at);
    bv_ic = 0; bl_ic = 0; bv_dc = 0; bl_dc = 0;
    for (int i = 0; i < n; i++) begin
      axi.rvalid = 1'b1;
      axi.rid    = id;
      axi.rdata  = 32'hA500_0000 + 32'(i) + {id, 28'd0};
      axi.rlast  = (i == last_at);
      @(negedge aclk);
      if (ic_ret_valid) bv_ic++;
      if (ic_ret_last)  bl_ic++;
      if (dc_ret_valid) bv_dc++;
      if (dc_ret_last)  bl_dc++;
      tick();
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
  endtask

  task automatic dc_req(logic [2:0] t, logic [AW-1:0] a);
    dc_rd_req = 1'b1; dc_rd_type = t; dc_rd_addr = a;
  endtask

  task automatic ic_req(logic [2:0] t, logic [AW-1:0] a);
    ic_rd_req = 1'b1; ic_rd_type = t; ic_rd_addr = a;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_bad++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0;
    axi.rdata = '0; axi.rlast = 1'b0;
    aresetn = 1'b0;
    repeat (3) tick();
    chk_on = 1'b1;
    @(negedge aclk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_arvalid", 64'(axi.arvalid), 64'(0));
    chk("rst_rready", 64'(axi.rready), 64'(0));
    chk("rst_perr", 64'(protocol_err), 64'(0));
    tick();
    aresetn = 1'b1;
    tick();

    // line refill from dcache
    dc_req(3'b100, 32'h1FC0_0040);
    @(negedge aclk);
    chk("t1_dc_rdy", 64'(dc_rd_rdy), 64'(1));
    chk("t1_ic_rdy", 64'(ic_rd_rdy), 64'(0));
    tick();
    dc_rd_req = 1'b0;
    @(negedge aclk);
    chk("t1_arvalid", 64'(axi.arvalid), 64'(1));
    chk("t1_arid", 64'(axi.arid), 64'(1));
    chk("t1_arlen", 64'(axi.arlen), 64'(15));
    chk("t1_arsize", 64'(axi.arsize), 64'(2));
    chk("t1_araddr", 64'(axi.araddr), 64'(32'h1FC0_0040));
    tick();
    do_ar();
    beats(4'd1, 16, 15);
    chk("t1_dc_beats", 64'(bv_dc), 64'(16));
    chk("t1_dc_lasts", 64'(bl_dc), 64'(1));
    chk("t1_ic_beats", 64'(bv_ic), 64'(0));

    // uncached half-word from icache
    ic_req(3'b001, 32'h0000_0102);
    tick();
    ic_rd_req = 1'b0;
    @(negedge aclk);
    chk("t3_arid", 64'(axi.arid), 64'(0));
    chk("t3_arlen", 64'(axi.arlen), 64'(0));
    chk("t3_arsize", 64'(axi.arsize), 64'(1));
    tick();
    do_ar();
    beats(4'd0, 1, 0);
    chk("t3_ic_valid", 64'(bv_ic), 64'(1));
    chk("t3_ic_last", 64'(bl_ic), 64'(1));
    @(negedge aclk);
    chk("t3_busy_after", 64'(busy), 64'(0));
    tick();

    // simultaneous requests: dc first, ic right after dc's last beat
    ic_req(3'b010, 32'h0000_1000);
    dc_req(3'b010, 32'h0000_2000);
    @(negedge aclk);
    chk("t2_dc_first", 64'(dc_rd_rdy), 64'(1));
    chk("t2_ic_held", 64'(ic_rd_rdy), 64'(0));
    tick();
    dc_rd_req = 1'b0;
    do_ar();
    beats(4'd1, 1, 0);
    @(negedge aclk);
    chk("t2_ic_served", 64'(ic_rd_rdy), 64'(1));
    tick();
    ic_rd_req = 1'b0;
    do_ar();
    beats(4'd0, 1, 0);
    chk("t2_ic_return", 64'(bv_ic), 64'(1));

    // two contests in a row: dc wins the first, second depends on policy
    ic_req(3'b010, 32'h0000_1100);
    dc_req(3'b010, 32'h0000_2100);
    tick();
    ic_rd_req = 1'b0; dc_rd_req = 1'b0;
    do_ar();
    beats(4'd1, 1, 0);
    ic_req(3'b010, 32'h0000_1200);
    dc_req(3'b010, 32'h0000_2200);
    @(negedge aclk);
    chk("rr_ic_rdy", 64'(ic_rd_rdy), 64'(RR));
    chk("rr_dc_rdy", 64'(dc_rd_rdy), 64'(!RR));
    tick();
    ic_rd_req = 1'b0; dc_rd_req = 1'b0;
    do_ar();
    beats(RR ? 4'd0 : 4'd1, 1, 0);

    // arready stall for 5 cycles
    dc_req(3'b010, 32'h3000_0010);
    tick();
    dc_rd_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("t4_arvalid_hold", 64'(axi.arvalid), 64'(1));
      chk("t4_araddr_hold", 64'(axi.araddr), 64'(32'h3000_0010));
      tick();
    end
    do_ar();
    @(negedge aclk);
    chk("t4_single_hs", 64'(axi.arvalid), 64'(0));
    tick();
    beats(4'd1, 1, 0);

    // early rlast on beat 8 of 16
    dc_req(3'b100, 32'h0000_0400);
    tick();
    dc_rd_req = 1'b0;
    do_ar();
    beats(4'd1, 8, 7);
    @(negedge aclk);
    chk("t5_perr", 64'(protocol_err), 64'(1));
    chk("t5_idle", 64'(busy), 64'(0));
    tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tick();

    // foreign rid during a dcache burst
    dc_req(3'b100, 32'h0000_0500);
    tick();
    dc_rd_req = 1'b0;
    do_ar();
    beats(4'd2, 1, 99);
    chk("t5b_dropped", 64'(bv_dc + bv_ic), 64'(0));
    @(negedge aclk);
    chk("t5b_perr", 64'(protocol_err), 64'(1));
    chk("t5b_still_busy", 64'(busy), 64'(1));
    tick();
    beats(4'd1, 16, 15);
    chk("t5b_dc_beats", 64'(bv_dc), 64'(16));

    // final beat without rlast: ret_last forced
    dc_req(3'b100, 32'h0000_0580);
    tick();
    dc_rd_req = 1'b0;
    do_ar();
    beats(4'd1, 16, 99);
    chk("t5c_forced_last", 64'(bl_dc), 64'(1));
    @(negedge aclk);
    chk("t5c_idle", 64'(busy), 64'(0));
    tick();

    // reset during beat 4 of a line refill
    dc_req(3'b100, 32'h0000_0600);
    tick();
    dc_rd_req = 1'b0;
    do_ar();
    beats(4'd1, 3, 99);
    axi.rvalid = 1'b1; axi.rid = 4'd1; axi.rdata = 32'h0BAD_0004;
    aresetn = 1'b0;
    tick();
    axi.rvalid = 1'b0;
    @(negedge aclk);
    chk("t6_arvalid", 64'(axi.arvalid), 64'(0));
    chk("t6_rready", 64'(axi.rready), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    chk("t6_perr", 64'(protocol_err), 64'(0));
    tick();
    aresetn = 1'b1;
    ic_req(3'b010, 32'h0000_0700);
    @(negedge aclk);
    chk("t6_fresh_accept", 64'(ic_rd_rdy), 64'(1));
    tick();
    ic_rd_req = 1'b0;
    do_ar();
    beats(4'd0, 1, 0);
    chk("t6_fresh_return", 64'(bv_ic), 64'(1));
    @(negedge aclk);
    chk("end_idle", 64'(busy), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
